// File: rtl/ps2_mouse_tracker_if.sv
// Byte stream from the PS/2 receiver into the mouse packet tracker.
interface ps2_mouse_tracker_if;
    logic       byte_valid;
    logic [7:0] byte_data;

    modport master (output byte_valid, output byte_data);
    modport slave  (input  byte_valid, input  byte_data);
endinterface

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse stream packet assembler with timeout recovery, clamped absolute
// cursor integration and button level/edge reporting.
module ps2_mouse_tracker #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int INIT_X         = 320,
    parameter int INIT_Y         = 240,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                      clk,
    input  logic                      rstn,
    ps2_mouse_tracker_if.slave        bus,
    output logic [9:0]                cursor_x,
    output logic [8:0]                cursor_y,
    output logic                      btn_left,
    output logic                      btn_right,
    output logic                      btn_middle,
    output logic                      left_press,
    output logic                      pkt_valid,
    output logic [7:0]                sync_errs
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - 1);
    localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - 1);

    typedef enum logic [1:0] {B0, B1, B2} state_t;

    // flags_q packs the useful flag bits: {Yovf, Xovf, Ysign, Xsign, M, R, L}
    state_t        state_q, state_d;
    logic [6:0]    flags_q, flags_d;
    logic [7:0]    xbyte_q, xbyte_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [9:0]    cursor_x_q, cursor_x_d;
    logic [8:0]    cursor_y_q, cursor_y_d;
    logic [2:0]    btn_q, btn_d;
    logic          left_press_q, left_press_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic [7:0]    sync_errs_q, sync_errs_d;

    logic                err_inc;
    logic signed [11:0]  dx, dy, nx, ny;

    // Next-state: packet FSM, timeout, and commit of the assembled packet.
    // The commit is computed from the third byte directly so its results
    // register on the same edge the byte is taken (outputs one clk later).
    always_comb begin
        state_d      = state_q;
        flags_d      = flags_q;
        xbyte_d      = xbyte_q;
        tmo_d        = '0;
        cursor_x_d   = cursor_x_q;
        cursor_y_d   = cursor_y_q;
        btn_d        = btn_q;
        left_press_d = 1'b0;
        pkt_valid_d  = 1'b0;
        err_inc      = 1'b0;

        dx = flags_q[5] ? '0 : {{3{flags_q[3]}}, flags_q[3], xbyte_q};
        dy = flags_q[6] ? '0 : {{3{flags_q[4]}}, flags_q[4], bus.byte_data};
        nx = $signed({2'b00, cursor_x_q}) + dx;
        ny = $signed({3'b000, cursor_y_q}) - dy;

        if (bus.byte_valid) begin
            unique case (state_q)
                B0: begin
                    if (bus.byte_data[3]) begin
                        flags_d = {bus.byte_data[7:4], bus.byte_data[2:0]};
                        state_d = B1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                B1: begin
                    xbyte_d = bus.byte_data;
                    state_d = B2;
                end
                B2: begin
                    state_d = B0;
                    if (nx < 0)          cursor_x_d = '0;
                    else if (nx > X_MAX) cursor_x_d = X_MAX[9:0];
                    else                 cursor_x_d = nx[9:0];
                    if (ny < 0)          cursor_y_d = '0;
                    else if (ny > Y_MAX) cursor_y_d = Y_MAX[8:0];
                    else                 cursor_y_d = ny[8:0];
                    btn_d        = flags_q[2:0];
                    left_press_d = flags_q[0] & ~btn_q[0];
                    pkt_valid_d  = 1'b1;
                end
                default: state_d = B0;
            endcase
        end else if (state_q != B0) begin
            if (tmo_q == TMO_LAST) begin
                state_d = B0;
                err_inc = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        sync_errs_d = sync_errs_q;
        if (err_inc && (sync_errs_q != 8'hFF))
            sync_errs_d = sync_errs_q + 8'd1;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= B0;
            flags_q      <= '0;
            xbyte_q      <= '0;
            tmo_q        <= '0;
            cursor_x_q   <= 10'(INIT_X);
            cursor_y_q   <= 9'(INIT_Y);
            btn_q        <= '0;
            left_press_q <= 1'b0;
            pkt_valid_q  <= 1'b0;
            sync_errs_q  <= '0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            xbyte_q      <= xbyte_d;
            tmo_q        <= tmo_d;
            cursor_x_q   <= cursor_x_d;
            cursor_y_q   <= cursor_y_d;
            btn_q        <= btn_d;
            left_press_q <= left_press_d;
            pkt_valid_q  <= pkt_valid_d;
            sync_errs_q  <= sync_errs_d;
        end
    end

    assign cursor_x   = cursor_x_q;
    assign cursor_y   = cursor_y_q;
    assign btn_left   = btn_q[0];
    assign btn_right  = btn_q[1];
    assign btn_middle = btn_q[2];
    assign left_press = left_press_q;
    assign pkt_valid  = pkt_valid_q;
    assign sync_errs  = sync_errs_q;

endmodule
